// File: rtl/l1_dcache.sv
// l1_dcache: direct-mapped, write-back, write-allocate L1 data cache.
// Serves the MEM-stage word/byte port, including two-phase indirect
// accesses (phase 1 fetches a pointer, phase 2 accesses through it), and
// fills/evicts 128-bit lines over the physical-memory port.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   S_IDLE    | lookup with EA = mem_address (direct, or indirect phase 1)
//   S_IND     | indirect phase 2, lookup with EA = latched pointer
//   S_WB      | writing the dirty victim line back to pmem
//   S_FILL    | fetching the missing line from pmem
module l1_dcache #(
  parameter int NUM_SETS = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  input  logic [15:0]  mem_wdata,
  input  logic         indirect,
  output logic [15:0]  mem_rdata,
  output logic         mem_resp,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int IW = $clog2(NUM_SETS);
  localparam int TW = 12 - IW;

  typedef enum logic [1:0] {S_IDLE, S_IND, S_WB, S_FILL} state_e;

  state_e          state_q, state_d;
  logic [15:0]     ptr_q, ptr_d;
  logic            ret_ind_q, ret_ind_d;
  logic [TW-1:0]   miss_tag_q, miss_tag_d;
  logic [IW-1:0]   miss_idx_q, miss_idx_d;

  logic [NUM_SETS-1:0] valid_q, dirty_q;
  logic [TW-1:0]       tag_q  [NUM_SETS];
  logic [127:0]        data_q [NUM_SETS];

  logic [15:0]   ea;
  logic [IW-1:0] ea_idx;
  logic [TW-1:0] ea_tag;
  logic [2:0]    ea_word;
  logic [6:0]    sel_lo, sel_hi;
  logic [127:0]  line;
  logic [127:0]  wline;
  logic [15:0]   word;
  logic          req, lookup, hit, do_write, fill_done;
  logic          unused_addr_bit;

  // Address decode, hit detection and write-merge of the looked-up line.
  always_comb begin
    ea       = (state_q == S_IND) ? ptr_q : mem_address;
    ea_idx   = ea[IW+3:4];
    ea_tag   = ea[15:IW+4];
    ea_word  = ea[3:1];
    sel_lo   = {ea_word, 4'b0000};
    sel_hi   = {ea_word, 4'b1000};
    line     = data_q[ea_idx];
    word     = line[sel_lo +: 16];
    req      = mem_read | mem_write;
    lookup   = req && (state_q == S_IDLE || state_q == S_IND);
    hit      = lookup && valid_q[ea_idx] && (tag_q[ea_idx] == ea_tag);
    // Indirect phase 1 only fetches the pointer; it never completes.
    mem_resp = hit && !(state_q == S_IDLE && indirect);
    mem_rdata = hit ? word : 16'h0000;
    // Read and write together is treated as a write.
    do_write = mem_resp && mem_write;
    fill_done = (state_q == S_FILL) && pmem_resp;
    wline    = line;
    if (mem_byte_enable[0]) wline[sel_lo +: 8] = mem_wdata[7:0];
    if (mem_byte_enable[1]) wline[sel_hi +: 8] = mem_wdata[15:8];
  end

  assign unused_addr_bit = ea[0];

  // The line address is latched at the miss so pmem_address stays stable
  // even if the requester drops or changes its request mid-miss.
  always_comb begin
    pmem_read  = (state_q == S_FILL);
    pmem_write = (state_q == S_WB);
    pmem_wdata = data_q[miss_idx_q];
    if (state_q == S_WB) pmem_address = {tag_q[miss_idx_q], miss_idx_q, 4'b0000};
    else                 pmem_address = {miss_tag_q, miss_idx_q, 4'b0000};
  end

  // Next-state logic for the controller.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    ret_ind_d  = ret_ind_q;
    miss_tag_d = miss_tag_q;
    miss_idx_d = miss_idx_q;
    case (state_q)
      S_IDLE, S_IND: begin
        if (!req) begin
          state_d = S_IDLE;
          ptr_d   = 16'h0000;
        end else if (hit) begin
          if (state_q == S_IDLE && indirect) begin
            ptr_d   = word;
            state_d = S_IND;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          miss_tag_d = ea_tag;
          miss_idx_d = ea_idx;
          ret_ind_d  = (state_q == S_IND);
          state_d    = (valid_q[ea_idx] && dirty_q[ea_idx]) ? S_WB : S_FILL;
        end
      end
      S_WB: begin
        if (pmem_resp) begin
          if (req) begin
            state_d = S_FILL;
          end else begin
            state_d = S_IDLE;
            ptr_d   = 16'h0000;
          end
        end
      end
      S_FILL: begin
        if (pmem_resp) begin
          if (!req) begin
            state_d = S_IDLE;
            ptr_d   = 16'h0000;
          end else begin
            state_d = ret_ind_q ? S_IND : S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Controller registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= 16'h0000;
      ret_ind_q  <= 1'b0;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      ret_ind_q  <= ret_ind_d;
      miss_tag_q <= miss_tag_d;
      miss_idx_q <= miss_idx_d;
    end
  end

  // Valid/dirty bits: set on fill completion, dirty on write hit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_done) begin
      valid_q[miss_idx_q] <= 1'b1;
      dirty_q[miss_idx_q] <= 1'b0;
    end else if (do_write) begin
      dirty_q[ea_idx] <= 1'b1;
    end
  end

  // Tag and data arrays; contents are qualified by valid so no reset needed.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      data_q[miss_idx_q] <= pmem_rdata;
      tag_q[miss_idx_q]  <= miss_tag_q;
    end else if (do_write) begin
      data_q[ea_idx] <= wline;
    end
  end

endmodule

// File: tb/tb_l1_dcache.sv
// Directed testbench for l1_dcache with a fixed-latency pmem responder.
module tb_l1_dcache;

  localparam int LAT = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [15:0]  mem_address = '0;
  logic         mem_read = 1'b0;
  logic         mem_write = 1'b0;
  logic [1:0]   mem_byte_enable = '0;
  logic [15:0]  mem_wdata = '0;
  logic         indirect = 1'b0;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [127:0] mem [4096];
  logic [15:0]  rd_log [$];
  logic [15:0]  wr_log [$];
  logic [127:0] wrd_log [$];
  int           cnt = 0;
  bit           both_seen = 1'b0;

  l1_dcache #(.NUM_SETS(8)) dut (
    .clk(clk), .reset(reset),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata), .indirect(indirect),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  // Physical memory: responds LAT cycles after a request rises.
  always @(negedge clk) begin
    if (pmem_read && pmem_write) both_seen = 1'b1;
    if (!reset) begin
      pmem_resp = 1'b0;
      cnt = 0;
    end else if (pmem_resp) begin
      pmem_resp = 1'b0;
      cnt = 0;
    end else if (pmem_read || pmem_write) begin
      cnt++;
      if (cnt == LAT) begin
        pmem_resp = 1'b1;
        if (pmem_read) begin
          pmem_rdata = mem[pmem_address[15:4]];
          rd_log.push_back(pmem_address);
        end else begin
          mem[pmem_address[15:4]] = pmem_wdata;
          wr_log.push_back(pmem_address);
          wrd_log.push_back(pmem_wdata);
        end
      end
    end
  end

  task automatic access(input logic wr, input logic [15:0] addr, input logic [1:0] be,
                        input logic [15:0] wd, input logic ind,
                        output logic [15:0] rd, output int cyc, output bit ok);
    @(posedge clk); #1;
    mem_address = addr; mem_read = !wr; mem_write = wr;
    mem_byte_enable = be; mem_wdata = wd; indirect = ind;
    cyc = 0; ok = 1'b0; rd = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cyc++;
      if (mem_resp) begin
        rd = mem_rdata;
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0; indirect = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (mem_resp !== 1'b0) begin errors++; $display("FAIL reset_mem_resp got %b want 0", mem_resp); end
    checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL reset_pmem_read got %b want 0", pmem_read); end
    checks++; if (pmem_write !== 1'b0) begin errors++; $display("FAIL reset_pmem_write got %b want 0", pmem_write); end
    checks++; if (mem_rdata !== 16'h0000) begin errors++; $display("FAIL reset_mem_rdata got %h want 0000", mem_rdata); end
    #1 reset = 1'b1;
  endtask

  task automatic test_cold_read();
    logic [15:0] rd; int cyc; bit ok; int nr, nw;
    nr = rd_log.size();
    access(1'b0, 16'h1234, 2'b00, 16'h0, 1'b0, rd, cyc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL cold_timeout got no resp want resp"); end
    checks++; if (rd_log.size() != nr + 1 || rd_log[nr] !== 16'h1230) begin errors++; $display("FAIL cold_fill_addr got %h want 1230", rd_log[nr]); end
    checks++; if (rd !== 16'h5678) begin errors++; $display("FAIL cold_rdata got %h want 5678", rd); end
    checks++; if (cyc != 5) begin errors++; $display("FAIL cold_latency got %0d want 5", cyc); end
    nr = rd_log.size(); nw = wr_log.size();
    access(1'b0, 16'h1234, 2'b00, 16'h0, 1'b0, rd, cyc, ok);
    checks++; if (cyc != 1 || !ok) begin errors++; $display("FAIL hit_latency got %0d want 1", cyc); end
    checks++; if (rd !== 16'h5678) begin errors++; $display("FAIL hit_rdata got %h want 5678", rd); end
    checks++; if (rd_log.size() != nr || wr_log.size() != nw) begin errors++; $display("FAIL hit_pmem_idle got %0d want %0d", rd_log.size() + wr_log.size(), nr + nw); end
  endtask

  task automatic test_write_evict();
    logic [15:0] rd; int cyc; bit ok; int nr, nw;
    access(1'b1, 16'h1234, 2'b10, 16'hAB00, 1'b0, rd, cyc, ok);
    checks++; if (cyc != 1 || !ok) begin errors++; $display("FAIL write_hit_latency got %0d want 1", cyc); end
    access(1'b0, 16'h1234, 2'b00, 16'h0, 1'b0, rd, cyc, ok);
    checks++; if (rd !== 16'hAB78) begin errors++; $display("FAIL write_merge got %h want ab78", rd); end
    nr = rd_log.size(); nw = wr_log.size();
    access(1'b0, 16'h2234, 2'b00, 16'h0, 1'b0, rd, cyc, ok);
    checks++; if (wr_log.size() != nw + 1 || wr_log[nw] !== 16'h1230) begin errors++; $display("FAIL evict_addr got %h want 1230", wr_log[nw]); end
    checks++; if (wrd_log[nw][47:32] !== 16'hAB78) begin errors++; $display("FAIL evict_word got %h want ab78", wrd_log[nw][47:32]); end
    checks++; if (wrd_log[nw][31:16] !== 16'h0919) begin errors++; $display("FAIL evict_neighbour got %h want 0919", wrd_log[nw][31:16]); end
    checks++; if (rd_log.size() != nr + 1 || rd_log[nr] !== 16'h2230) begin errors++; $display("FAIL evict_fill_addr got %h want 2230", rd_log[nr]); end
    checks++; if (rd !== 16'h111A) begin errors++; $display("FAIL evict_rdata got %h want 111a", rd); end
    checks++; if (cyc != 9) begin errors++; $display("FAIL dirty_latency got %0d want 9", cyc); end
  endtask

  task automatic test_ldi();
    logic [15:0] rd; int cyc; bit ok; int nr, nw;
    nr = rd_log.size(); nw = wr_log.size();
    access(1'b0, 16'h0040, 2'b00, 16'h0, 1'b1, rd, cyc, ok);
    checks++; if (rd !== 16'hBEEF || !ok) begin errors++; $display("FAIL ldi_rdata got %h want beef", rd); end
    checks++; if (rd_log.size() != nr + 2 || rd_log[nr] !== 16'h0040 || rd_log[nr+1] !== 16'h0100) begin errors++; $display("FAIL ldi_fills got %0d fills want 2 (0040,0100)", rd_log.size() - nr); end
    checks++; if (cyc != 10) begin errors++; $display("FAIL ldi_latency got %0d want 10", cyc); end
    checks++; if (wr_log.size() != nw) begin errors++; $display("FAIL ldi_no_wb got %0d want %0d", wr_log.size(), nw); end
  endtask

  task automatic test_sti();
    logic [15:0] rd; int cyc; bit ok; int nr, nw;
    nr = rd_log.size();
    access(1'b1, 16'h0040, 2'b11, 16'h1111, 1'b1, rd, cyc, ok);
    checks++; if (cyc != 2 || !ok) begin errors++; $display("FAIL sti_latency got %0d want 2", cyc); end
    checks++; if (rd_log.size() != nr) begin errors++; $display("FAIL sti_no_fill got %0d want %0d", rd_log.size(), nr); end
    access(1'b0, 16'h0102, 2'b00, 16'h0, 1'b0, rd, cyc, ok);
    checks++; if (rd !== 16'h1111 || cyc != 1) begin errors++; $display("FAIL sti_readback got %h/%0d want 1111/1", rd, cyc); end
    nr = rd_log.size(); nw = wr_log.size();
    access(1'b0, 16'h0902, 2'b00, 16'h0, 1'b0, rd, cyc, ok);
    checks++; if (wr_log.size() != nw + 1 || wr_log[nw] !== 16'h0100 || wrd_log[nw][31:16] !== 16'h1111) begin errors++; $display("FAIL sti_dirty_wb got %h want 0100 with word 1111", wr_log[nw]); end
    checks++; if (rd !== 16'h0481 || rd_log[nr] !== 16'h0900) begin errors++; $display("FAIL sti_refill got %h want 0481", rd); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd; int cyc; bit ok; int nr, nw;
    logic [15:0] addrs [3];
    logic [15:0] exps [3];
    addrs[0] = 16'h0010; addrs[1] = 16'h0012; addrs[2] = 16'h0014;
    exps[0] = 16'h0008; exps[1] = 16'h0009; exps[2] = 16'h000A;
    access(1'b0, 16'h0010, 2'b00, 16'h0, 1'b0, rd, cyc, ok);
    checks++; if (rd !== 16'h0008 || cyc != 5) begin errors++; $display("FAIL b2b_warm got %h/%0d want 0008/5", rd, cyc); end
    nr = rd_log.size(); nw = wr_log.size();
    @(posedge clk); #1;
    mem_read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_address = addrs[i];
      @(negedge clk);
      checks++;
      if (mem_resp !== 1'b1 || mem_rdata !== exps[i] || pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
        errors++; $display("FAIL b2b_hit%0d got resp %b data %h want resp 1 data %h", i, mem_resp, mem_rdata, exps[i]);
      end
      @(posedge clk); #1;
    end
    mem_read = 1'b0;
    checks++; if (rd_log.size() != nr || wr_log.size() != nw) begin errors++; $display("FAIL b2b_pmem_idle got %0d want %0d", rd_log.size() + wr_log.size(), nr + nw); end
  endtask

  task automatic test_reset_mid_fill();
    logic [15:0] rd; int cyc; bit ok; bit seen; int nr;
    seen = 1'b0;
    @(posedge clk); #1;
    mem_address = 16'h3000; mem_read = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pmem_read) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL midfill_start got no pmem_read want pmem_read"); end
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    checks++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || mem_resp !== 1'b0) begin errors++; $display("FAIL midfill_drop got rd %b wr %b resp %b want 0 0 0", pmem_read, pmem_write, mem_resp); end
    mem_read = 1'b0;
    @(negedge clk); #1;
    reset = 1'b1;
    nr = rd_log.size();
    access(1'b0, 16'h3000, 2'b00, 16'h0, 1'b0, rd, cyc, ok);
    checks++; if (cyc != 5 || rd_log.size() != nr + 1 || rd_log[nr] !== 16'h3000) begin errors++; $display("FAIL midfill_refill got %0d cycles want 5 with fill 3000", cyc); end
    checks++; if (rd !== 16'h1800) begin errors++; $display("FAIL midfill_rdata got %h want 1800", rd); end
    access(1'b0, 16'h0010, 2'b00, 16'h0, 1'b0, rd, cyc, ok);
    checks++; if (cyc != 5 || rd !== 16'h0008) begin errors++; $display("FAIL reset_invalidates got %0d/%h want 5/0008", cyc, rd); end
  endtask

  task automatic test_pmem_exclusive();
    checks++; if (both_seen !== 1'b0) begin errors++; $display("FAIL pmem_exclusive got both high want never"); end
  endtask

  initial begin
    for (int l = 0; l < 4096; l++)
      for (int k = 0; k < 8; k++)
        mem[l][k*16 +: 16] = 16'((l * 8) + k);
    mem[12'h123][47:32] = 16'h5678;
    mem[12'h004][15:0]  = 16'h0102;
    mem[12'h010][31:16] = 16'hBEEF;

    test_reset();
    test_cold_read();
    test_write_evict();
    test_ldi();
    test_sti();
    test_back_to_back();
    test_reset_mid_fill();
    test_pmem_exclusive();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
